// File: rtl/clk_gate_ctrl_if.sv
// Bundle between the gate enable controller and the block that requests the
// gated clock. The master requests activity, the slave (the controller)
// reports the enable, readiness and debug state.
interface clk_gate_ctrl_if #(
    parameter int IDLE_CNT_W = 4
);
    logic                  active_req;
    logic                  busy;
    logic [IDLE_CNT_W-1:0] idle_thresh;
    logic                  test_en;
    logic                  clk_en;
    logic                  clk_ready;
    logic [1:0]            gate_state;

    modport master (
        output active_req,
        output busy,
        output idle_thresh,
        output test_en,
        input  clk_en,
        input  clk_ready,
        input  gate_state
    );

    modport slave (
        input  active_req,
        input  busy,
        input  idle_thresh,
        input  test_en,
        output clk_en,
        output clk_ready,
        output gate_state
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a clock-gating cell. Wakes the gated clock on request,
// holds off readiness for WAKE_CYCLES enabled cycles, and after activity stops
// keeps the clock running for a latched idle window before gating it off.
// Everything runs on the free-running clock that also feeds the gate cell.
module clk_gate_ctrl #(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CNT_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_gate_ctrl_if.slave gate_if
);

    localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WCNT_W-1:0]     WCNT_LAST = WCNT_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] ICNT_MAX  = {IDLE_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WAKE  = 2'b01,
        ST_ON    = 2'b10,
        ST_DRAIN = 2'b11
    } gate_state_e;

    gate_state_e           state_r;
    gate_state_e           state_nxt_s;
    logic [WCNT_W-1:0]     wcnt_r;
    logic [WCNT_W-1:0]     wcnt_nxt_s;
    logic [IDLE_CNT_W-1:0] icnt_r;
    logic [IDLE_CNT_W-1:0] icnt_nxt_s;
    logic [IDLE_CNT_W-1:0] thr_r;
    logic [IDLE_CNT_W-1:0] thr_nxt_s;
    logic                  en_r;
    logic                  en_nxt_s;
    logic                  ready_r;
    logic                  ready_nxt_s;
    logic [1:0]            gate_state_r;
    logic                  idle_s;

    assign idle_s = !gate_if.active_req && !gate_if.busy;

    // Next-state, counter and output decode for the gating FSM.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        icnt_nxt_s  = icnt_r;
        thr_nxt_s   = thr_r;
        case (state_r)
            ST_OFF: begin
                // Busy alone never wakes the clock; only a request does.
                if (gate_if.active_req) begin
                    state_nxt_s = ST_WAKE;
                    wcnt_nxt_s  = {WCNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_WAKE: begin
                // Wake always runs to completion, even if the request drops.
                if (wcnt_r == WCNT_LAST) begin
                    state_nxt_s = ST_ON;
                end else begin
                    wcnt_nxt_s = wcnt_r + WCNT_W'(1);
                end
            end
            ST_ON: begin
                if (idle_s) begin
                    state_nxt_s = ST_DRAIN;
                    icnt_nxt_s  = {IDLE_CNT_W{1'b0}};
                    thr_nxt_s   = gate_if.idle_thresh;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_DRAIN: begin
                // A renewed request beats the timeout on the same edge.
                if (!idle_s) begin
                    state_nxt_s = ST_ON;
                    icnt_nxt_s  = {IDLE_CNT_W{1'b0}};
                end else if (icnt_r >= thr_r) begin
                    state_nxt_s = ST_OFF;
                end else if (icnt_r != ICNT_MAX) begin
                    icnt_nxt_s = icnt_r + IDLE_CNT_W'(1);
                end else begin
                    icnt_nxt_s = icnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
                wcnt_nxt_s  = {WCNT_W{1'b0}};
                icnt_nxt_s  = {IDLE_CNT_W{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        en_nxt_s    = (state_nxt_s != ST_OFF);
        ready_nxt_s = (state_nxt_s == ST_ON) || (state_nxt_s == ST_DRAIN);
    end

    // State, counters and registered outputs; reset clears all without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_OFF;
            wcnt_r       <= {WCNT_W{1'b0}};
            icnt_r       <= {IDLE_CNT_W{1'b0}};
            thr_r        <= {IDLE_CNT_W{1'b0}};
            en_r         <= 1'b0;
            ready_r      <= 1'b0;
            gate_state_r <= 2'b00;
        end else begin
            state_r      <= state_nxt_s;
            wcnt_r       <= wcnt_nxt_s;
            icnt_r       <= icnt_nxt_s;
            thr_r        <= thr_nxt_s;
            en_r         <= en_nxt_s;
            ready_r      <= ready_nxt_s;
            gate_state_r <= state_nxt_s;
        end
    end

    // Test override is a pure OR onto the registered enable so scan can force
    // the clock on at once; FSM and status outputs ignore it.
    assign gate_if.clk_en     = en_r | gate_if.test_en;
    assign gate_if.clk_ready  = ready_r;
    assign gate_if.gate_state = gate_state_r;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (WAKE_CYCLES=2, IDLE_CNT_W=4).
module tb_clk_gate_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    clk_gate_ctrl_if #(.IDLE_CNT_W(4)) gif ();

    clk_gate_ctrl #(
        .WAKE_CYCLES (2),
        .IDLE_CNT_W  (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gate_if (gif)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic rdy, input logic [1:0] st);
        check_val({tag, ".clk_en"},     {7'd0, gif.clk_en},     {7'd0, en});
        check_val({tag, ".clk_ready"},  {7'd0, gif.clk_ready},  {7'd0, rdy});
        check_val({tag, ".gate_state"}, {6'd0, gif.gate_state}, {6'd0, st});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From OFF with a request already applied: WAKE, WAKE, ON.
    task automatic wake_up(input string tag);
        tick(); check_out({tag, ".w0"}, 1'b1, 1'b0, 2'b01);
        tick(); check_out({tag, ".w1"}, 1'b1, 1'b0, 2'b01);
        tick(); check_out({tag, ".on"}, 1'b1, 1'b1, 2'b10);
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        gif.active_req  = 1'b1;
        gif.busy        = 1'b0;
        gif.idle_thresh = 4'd3;
        gif.test_en     = 1'b0;

        // Reset held with a request pending: everything stays off.
        tick(); tick();
        check_out("rst_hold", 1'b0, 1'b0, 2'b00);

        // Release between edges; the next edge enters WAKE, ready two edges later.
        rst_n = 1'b1;
        check_out("rst_rel", 1'b0, 1'b0, 2'b00);
        wake_up("wake1");

        // Idle timeout with threshold 3: four DRAIN cycles, then OFF.
        gif.active_req = 1'b0;
        tick(); check_out("idle.d0", 1'b1, 1'b1, 2'b11);
        for (int i = 1; i <= 3; i++) begin
            tick(); check_out($sformatf("idle.d%0d", i), 1'b1, 1'b1, 2'b11);
        end
        tick(); check_out("idle.off", 1'b0, 1'b0, 2'b00);

        // Request dropped during WAKE: wake still completes.
        gif.active_req = 1'b1;
        tick(); check_out("wabort.w0", 1'b1, 1'b0, 2'b01);
        gif.active_req = 1'b0;
        tick(); check_out("wabort.w1", 1'b1, 1'b0, 2'b01);
        tick(); check_out("wabort.on", 1'b1, 1'b1, 2'b10);

        // Drain abort: busy pulse at icnt=2 returns to ON, then a full window again.
        tick(); check_out("dab.d0", 1'b1, 1'b1, 2'b11);
        tick(); check_out("dab.d1", 1'b1, 1'b1, 2'b11);
        tick(); check_out("dab.d2", 1'b1, 1'b1, 2'b11);
        gif.busy = 1'b1;
        tick(); check_out("dab.on", 1'b1, 1'b1, 2'b10);
        gif.busy = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            tick(); check_out($sformatf("dab.r%0d", i), 1'b1, 1'b1, 2'b11);
        end
        tick(); check_out("dab.off", 1'b0, 1'b0, 2'b00);

        // Zero threshold: exactly one DRAIN cycle.
        gif.active_req = 1'b1;
        wake_up("wake0");
        gif.idle_thresh = 4'd0;
        gif.active_req  = 1'b0;
        tick(); check_out("thr0.d0", 1'b1, 1'b1, 2'b11);
        tick(); check_out("thr0.off", 1'b0, 1'b0, 2'b00);

        // Threshold lowered mid-DRAIN: the latched value of 3 still applies.
        gif.idle_thresh = 4'd3;
        gif.active_req  = 1'b1;
        wake_up("wakec");
        gif.active_req = 1'b0;
        tick(); check_out("thrc.d0", 1'b1, 1'b1, 2'b11);
        gif.idle_thresh = 4'd0;
        for (int i = 1; i <= 3; i++) begin
            tick(); check_out($sformatf("thrc.d%0d", i), 1'b1, 1'b1, 2'b11);
        end
        tick(); check_out("thrc.off", 1'b0, 1'b0, 2'b00);

        // Request returns on the edge DRAIN would exit: goes to ON.
        gif.active_req = 1'b1;
        wake_up("wakes");
        gif.active_req = 1'b0;
        tick(); check_out("sim.d0", 1'b1, 1'b1, 2'b11);
        gif.active_req = 1'b1;
        tick(); check_out("sim.on", 1'b1, 1'b1, 2'b10);
        gif.active_req = 1'b0;
        tick(); check_out("sim.d1", 1'b1, 1'b1, 2'b11);
        tick(); check_out("sim.off", 1'b0, 1'b0, 2'b00);

        // Busy alone in OFF does not wake.
        gif.busy = 1'b1;
        tick(); check_out("busy_off", 1'b0, 1'b0, 2'b00);
        gif.busy = 1'b0;

        // Test override in OFF: enable within the same cycle, FSM untouched.
        gif.test_en = 1'b1;
        #1; check_out("test.on", 1'b1, 1'b0, 2'b00);
        tick(); check_out("test.hold", 1'b1, 1'b0, 2'b00);
        gif.test_en = 1'b0;
        #1; check_out("test.rel", 1'b0, 1'b0, 2'b00);

        // Async reset between edges in DRAIN: outputs clear immediately.
        gif.idle_thresh = 4'd3;
        gif.active_req  = 1'b1;
        wake_up("waker");
        gif.active_req = 1'b0;
        tick(); check_out("arst.d0", 1'b1, 1'b1, 2'b11);
        #2 rst_n = 1'b0;
        #1; check_out("arst.now", 1'b0, 1'b0, 2'b00);
        #2 rst_n = 1'b1;
        tick(); check_out("arst.after", 1'b0, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Enable controller that sits directly upstream of the clock-gating cell and drives its CLK_EN input.
- Turns the gated clock on when the downstream domain requests activity.
- Waits a fixed number of enabled cycles before declaring the clock ready.
- After activity stops, keeps the clock running for a programmable idle window, then gates it off.
- Runs entirely on the free-running clock that also feeds the gate cell.

Parameters:
- WAKE_CYCLES, 2: enabled cycles from CLK_EN rise to CLK_READY rise; legal range is 1 or more.
- IDLE_CNT_W, 4: width of the idle threshold and the idle counter.

Ports:
- CLK  in  1  free-running clock, the same clock fed to the gate cell.
- RST  in  1  asynchronous active-low reset.
- ACTIVE_REQ  in  1  downstream domain requests the clock; level-sensitive.
- BUSY  in  1  gated domain still has work in flight.
- IDLE_THRESH  in  IDLE_CNT_W  extra idle cycles before gating off.
- TEST_EN  in  1  scan/test override; forces the clock on.
- CLK_EN  out  1  enable to the gate cell.
- CLK_READY  out  1  gated clock is stable and usable.
- GATE_STATE  out  2  current FSM state, for debug.

Behaviour:
- Reset: RST low clears everything immediately, with no clock needed:
  - state = OFF, CLK_EN = 0, CLK_READY = 0, GATE_STATE = 00, all counters = 0.
- Reset mid-operation (any state) takes effect the same way.
- Register timing: all state is updated on the CLK rising edge. CLK_EN changes only on rising edges, so the gate cell's low-phase latch is always given a stable enable.
- States and their outputs:
  - OFF (00): CLK_EN = 0, CLK_READY = 0.
  - WAKE (01): CLK_EN = 1, CLK_READY = 0.
  - ON (10): CLK_EN = 1, CLK_READY = 1.
  - DRAIN (11): CLK_EN = 1, CLK_READY = 1.
- Definition: idle = !ACTIVE_REQ && !BUSY.
- OFF:
  - ACTIVE_REQ = 1 -> WAKE, wake counter wcnt = 0.
  - BUSY alone does not wake the block.
- WAKE:
  - wcnt increments each cycle.
  - When wcnt == WAKE_CYCLES-1 -> ON.
  - WAKE always completes; dropping ACTIVE_REQ during WAKE does not abort it.
  - Result: CLK_READY rises exactly WAKE_CYCLES edges after CLK_EN rises.
- ON:
  - idle -> DRAIN; idle counter icnt = 0; IDLE_THRESH is latched into thr.
  - Otherwise stay in ON.
- DRAIN:
  - Not idle -> ON, icnt cleared.
  - Idle and icnt >= thr -> OFF.
  - Otherwise icnt increments, saturating at its maximum.
  - CLK_EN therefore stays high for thr+1 DRAIN cycles after the ON cycle that detected idle.
  - thr = 0 gives one DRAIN cycle.
  - Changes to IDLE_THRESH while in DRAIN are ignored until the next DRAIN entry.
- Simultaneous events:
  - ACTIVE_REQ rising on the same edge that DRAIN would exit to OFF: the not-idle check wins, so the next state is ON.
  - In OFF, ACTIVE_REQ sampled high always goes to WAKE, never straight to ON.
- TEST_EN:
  - CLK_EN = enable register OR TEST_EN; this path is combinational.
  - The FSM, CLK_READY and GATE_STATE are unaffected by TEST_EN.
- Outputs:
  - CLK_READY and GATE_STATE are registered.
  - Neither output glitches.

Test Plan:
- Reset: hold RST=0 with ACTIVE_REQ=1 -> CLK_EN=0, CLK_READY=0, GATE_STATE=00. Release RST -> CLK_EN=1 after the next edge.
- Wake (WAKE_CYCLES=2): ACTIVE_REQ=1 sampled at edge t -> CLK_EN=1 after t, GATE_STATE=01; CLK_READY=1 and GATE_STATE=10 after t+2.
- Idle timeout (IDLE_THRESH=3): in ON, drop ACTIVE_REQ and BUSY before edge e -> DRAIN after e; CLK_EN stays 1 through e+3, falls after e+4; CLK_READY falls with it; GATE_STATE=00.
- Drain abort: in DRAIN with icnt=2, pulse BUSY=1 for one cycle -> GATE_STATE=10, CLK_EN never drops. A subsequent idle run again needs thr+1 DRAIN cycles.
- Zero threshold and threshold change: IDLE_THRESH=0 -> exactly one DRAIN cycle, then OFF. Changing IDLE_THRESH from 3 to 0 mid-DRAIN does not shorten the window.
- Test override and async reset:
  - TEST_EN=1 in OFF -> CLK_EN=1 within the same cycle, CLK_READY=0, GATE_STATE=00.
  - RST pulsed low mid-DRAIN, between edges -> CLK_EN=0 immediately, without waiting for a clock edge.
